// File: rtl/pll_rst_seq_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// The sequencer takes the slave view and the surrounding logic takes the master view.
interface pll_rst_seq_if;
    logic pll_locked;
    logic soft_rst;
    logic lock_lost_clr;
    logic periph_rst_n;
    logic core_rst_n;
    logic ready;
    logic lock_lost;

    modport master (
        output pll_locked, soft_rst, lock_lost_clr,
        input  periph_rst_n, core_rst_n, ready, lock_lost
    );

    modport slave (
        input  pll_locked, soft_rst, lock_lost_clr,
        output periph_rst_n, core_rst_n, ready, lock_lost
    );
endinterface

// File: rtl/pll_rst_seq.sv
// Staged reset release after the PLL has stayed locked for a programmed time.
// Runs on the free-running oscillator so that a loss of lock is still seen.
module pll_rst_seq #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned LOCK_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pll_rst_seq_if.slave  bus
);
    localparam int unsigned MAX_CYCLES = (LOCK_CYCLES > STAGGER_CYCLES) ? LOCK_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, PERIPH, RUN} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   abort;
    logic                   periph_q, periph_d;
    logic                   core_q, core_d;
    logic                   ready_q, ready_d;
    logic                   lost_q, lost_d;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign abort    = !locked_s || bus.soft_rst;

    // Synchronizer, state, counter and every output are flops on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            ready_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (locked_s && !bus.soft_rst) state_d = STABLE;
            end
            STABLE: begin
                if (abort)                   state_d = WAIT_LOCK;
                else if (cnt_q == LOCK_LAST) state_d = PERIPH;
                else                         cnt_d   = cnt_q + CW'(1);
            end
            PERIPH: begin
                if (abort)                   state_d = WAIT_LOCK;
                else if (cnt_q == STAG_LAST) state_d = RUN;
                else                         cnt_d   = cnt_q + CW'(1);
            end
            RUN: begin
                if (abort) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Output levels follow the state being entered, so they register on the transition edge.
    always_comb begin
        periph_d = (state_d == PERIPH) || (state_d == RUN);
        core_d   = (state_d == RUN);
        ready_d  = (state_d == RUN);
        lost_d   = lost_q;
        if (bus.lock_lost_clr) lost_d = 1'b0;
        if (!locked_s && ((state_q == PERIPH) || (state_q == RUN))) lost_d = 1'b1;
    end

    assign bus.periph_rst_n = periph_q;
    assign bus.core_rst_n   = core_q;
    assign bus.ready        = ready_q;
    assign bus.lock_lost    = lost_q;
endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: edge-numbered steps with hand-computed expectations.
// Edge numbers count clk rising edges after rst_n release; sampling happens 1 ns after each edge.
module tb_pll_rst_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = -1;

    pll_rst_seq_if bus ();

    pll_rst_seq #(
        .SYNC_STAGES    (2),
        .LOCK_CYCLES    (16),
        .STAGGER_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @edge %0d: observed=%b expected=%b", tag, edge_cnt, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic p, input logic c, input logic r, input logic l);
        check({tag, ".periph_rst_n"}, bus.periph_rst_n, p);
        check({tag, ".core_rst_n"},   bus.core_rst_n,   c);
        check({tag, ".ready"},        bus.ready,        r);
        check({tag, ".lock_lost"},    bus.lock_lost,    l);
    endtask

    task automatic step_to(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
            edge_cnt++;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.pll_locked    = 1'b0;
        bus.soft_rst      = 1'b0;
        bus.lock_lost_clr = 1'b0;
        #12;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Power-up: lock rises between edge 0 and edge 1
        step_to(0);
        bus.pll_locked = 1'b1;
        step_to(18); check_all("pwr_e18", 1'b0, 1'b0, 1'b0, 1'b0);
        step_to(19); check_all("pwr_e19", 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(22); check_all("pwr_e22", 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(23); check_all("pwr_e23", 1'b1, 1'b1, 1'b1, 1'b0);

        // Lock loss in RUN: falls before edge 40, locked_s low after 41, abort on 42
        step_to(39);
        bus.pll_locked = 1'b0;
        step_to(41); check_all("loss_e41", 1'b1, 1'b1, 1'b1, 1'b0);
        step_to(42); check_all("loss_e42", 1'b0, 1'b0, 1'b0, 1'b1);
        bus.pll_locked = 1'b1;
        // locked_s high after 44, STABLE from 45, periph on 61, core on 65
        step_to(60); check_all("relock_e60", 1'b0, 1'b0, 1'b0, 1'b1);
        step_to(61); check_all("relock_e61", 1'b1, 1'b0, 1'b0, 1'b1);
        step_to(64); check_all("relock_e64", 1'b1, 1'b0, 1'b0, 1'b1);
        step_to(65); check_all("relock_e65", 1'b1, 1'b1, 1'b1, 1'b1);

        // Clear lock_lost on its own
        step_to(66);
        bus.lock_lost_clr = 1'b1;
        step_to(67);
        bus.lock_lost_clr = 1'b0;
        check_all("clr_e67", 1'b1, 1'b1, 1'b1, 1'b0);

        // soft_rst pulse in RUN, sampled on edge 71
        step_to(70);
        bus.soft_rst = 1'b1;
        step_to(71);
        bus.soft_rst = 1'b0;
        check_all("soft_e71", 1'b0, 1'b0, 1'b0, 1'b0);
        step_to(87); check_all("soft_e87", 1'b0, 1'b0, 1'b0, 1'b0);
        step_to(88); check_all("soft_e88", 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(91); check_all("soft_e91", 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(92); check_all("soft_e92", 1'b1, 1'b1, 1'b1, 1'b0);

        // Lock drop coinciding with lock_lost_clr: set wins on edge 98
        step_to(95);
        bus.pll_locked = 1'b0;
        step_to(97);
        bus.lock_lost_clr = 1'b1;
        check_all("setclr_e97", 1'b1, 1'b1, 1'b1, 1'b0);
        step_to(98);
        bus.lock_lost_clr = 1'b0;
        check_all("setclr_e98", 1'b0, 1'b0, 1'b0, 1'b1);
        step_to(100);
        bus.lock_lost_clr = 1'b1;
        step_to(101);
        bus.lock_lost_clr = 1'b0;
        check_all("clr_e101", 1'b0, 1'b0, 1'b0, 1'b0);

        // Relock, then drop while STABLE counter is 10 (STABLE entered on 104, abort on 115)
        bus.pll_locked = 1'b1;
        step_to(112);
        bus.pll_locked = 1'b0;
        step_to(115);
        check_all("stab_e115", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.pll_locked = 1'b1;
        // STABLE re-entered on 118 with a fresh count: periph on 134
        for (int e = 116; e <= 133; e++) begin
            step_to(e);
            check("stab_hold.periph_rst_n", bus.periph_rst_n, 1'b0);
        end
        step_to(134); check_all("stab_e134", 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(135); check_all("stab_e135", 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while in PERIPH
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        // Lock already high: locked_s after 137, STABLE on 138, periph on 154, core on 158
        step_to(137); check_all("rerun_e137", 1'b0, 1'b0, 1'b0, 1'b0);
        step_to(153); check_all("rerun_e153", 1'b0, 1'b0, 1'b0, 1'b0);
        step_to(154); check_all("rerun_e154", 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(157); check_all("rerun_e157", 1'b1, 1'b0, 1'b0, 1'b0);
        step_to(158); check_all("rerun_e158", 1'b1, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
